// File: rtl/normalize_pack.sv
`default_nettype none
// ============================================================================
//  Module      : normalize_pack
//  Description : Post add/sub stage of the binary16 FP adder. Accepts the raw
//                MW+1 bit mantissa sum, result sign and common aligned
//                exponent. It normalises one bit per cycle, then packs an
//                IEEE-754 binary16 word with truncation. It handles
//                carry-out, cancellation, subnormal, zero and overflow.
//  Ports       : clk, rst            - clock (rising edge), async active-high reset
//                i_in_valid/o_in_ready   - upstream handshake (ready only in IDLE)
//                i_res_sign, i_m_sum, i_exp_in - operands from the add/sub stage
//                o_out_valid/i_out_ready - downstream handshake
//                o_result            - {sign, exp[EW-1:0], frac[MW-2:0]}
//                o_out_ovf           - result saturated to +/-Inf
//                o_out_zero          - result is exact zero
//  Revision    : 1.0 - initial release
// ============================================================================
module normalize_pack #(
    parameter int MW = 11,
    parameter int EW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_res_sign,
    input  logic [MW:0]      i_m_sum,
    input  logic [EW-1:0]    i_exp_in,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [EW+MW-1:0] o_result,
    output logic             o_out_ovf,
    output logic             o_out_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Working exponent is one bit wider so a carry from exponent 30 reaches 31
    // (the Inf code) without wrapping.
    localparam logic [EW:0] c_E_ONE = (EW+1)'(1);
    localparam logic [EW:0] c_E_INF = {1'b0, {EW{1'b1}}};

    state_t            r_state;
    logic              r_s;
    logic [MW:0]       r_m;
    logic [EW:0]       r_e;
    logic              r_valid;
    logic [EW+MW-1:0]  r_result;
    logic              r_ovf;
    logic              r_zero;

    logic [EW:0]       w_exp_lat;
    logic              w_pack;

    // Exponent 0 encodes subnormals, whose effective exponent is 1.
    assign w_exp_lat = (i_exp_in == '0) ? c_E_ONE : {1'b0, i_exp_in};

    // Stop shifting once the hidden bit is set, nothing is left to normalise,
    // or the exponent floor is reached (result stays subnormal).
    assign w_pack = (r_m == '0) || r_m[MW-1] || (r_e == c_E_ONE);

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = r_valid;
    assign o_result    = r_result;
    assign o_out_ovf   = r_ovf;
    assign o_out_zero  = r_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_s      <= 1'b0;
            r_m      <= '0;
            r_e      <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_s     <= i_res_sign;
                        r_m     <= i_m_sum;
                        r_e     <= w_exp_lat;
                        r_state <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (r_m[MW]) begin
                        // Carry-out: renormalise right, LSB is truncated.
                        r_m <= r_m >> 1;
                        r_e <= r_e + c_E_ONE;
                    end else if (w_pack) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b1;
                        if (r_m == '0) begin
                            // Exact cancellation yields +0 regardless of sign.
                            r_result <= '0;
                            r_zero   <= 1'b1;
                        end else if (r_e >= c_E_INF) begin
                            r_result <= {r_s, {EW{1'b1}}, {(MW-1){1'b0}}};
                            r_ovf    <= 1'b1;
                        end else if (r_m[MW-1]) begin
                            r_result <= {r_s, r_e[EW-1:0], r_m[MW-2:0]};
                        end else begin
                            r_result <= {r_s, {EW{1'b0}}, r_m[MW-2:0]};
                        end
                    end else begin
                        r_m <= {r_m[MW-1:0], 1'b0};
                        r_e <= r_e - c_E_ONE;
                    end
                end

                S_DONE: begin
                    // Result is kept after the handshake; only the flags drop.
                    if (i_out_ready) begin
                        r_valid <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_zero  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_normalize_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_normalize_pack
//  Description : Self-checking bench for normalize_pack. A behavioural model
//                derives result, flags and latency from the leading-one
//                position; a negedge compare process checks the DUT against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_normalize_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic        i_res_sign = 1'b0;
    logic [11:0] i_m_sum = '0;
    logic [4:0]  i_exp_in = '0;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [15:0] o_result;
    logic        o_out_ovf;
    logic        o_out_zero;

    normalize_pack #(.MW(11), .EW(5)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_res_sign  (i_res_sign),
        .i_m_sum     (i_m_sum),
        .i_exp_in    (i_exp_in),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_out_ovf   (o_out_ovf),
        .o_out_zero  (o_out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        int          lat;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        pend = 1'b0;
    logic        seen = 1'b0;
    logic [15:0] last_result = '0;
    exp_t        exp_cur;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: locate the leading one, shift as far as the exponent floor
    // allows, and derive the edges needed from the shift count.
    function automatic exp_t model(input logic s, input logic [11:0] m, input logic [4:0] ex);
        exp_t        r;
        int          e0;
        int          e;
        int          p;
        int          k;
        logic [11:0] mm;
        r.res = '0; r.ovf = 1'b0; r.zero = 1'b0; r.lat = 1;
        e0 = (ex == 0) ? 1 : int'(ex);
        if (m == 0) begin
            r.zero = 1'b1;
            return r;
        end
        if (m[11]) begin
            e  = e0 + 1;
            mm = m >> 1;
            r.lat = 2;
        end else begin
            p = 0;
            for (int i = 0; i < 11; i++) if (m[i]) p = i;
            k = 10 - p;
            if (k > e0 - 1) k = e0 - 1;
            mm = m << k;
            e  = e0 - k;
            r.lat = 1 + k;
        end
        if (e >= 31) begin
            r.res = {s, 5'h1F, 10'h000};
            r.ovf = 1'b1;
        end else if (mm[10]) begin
            r.res = {s, 5'(e), mm[9:0]};
        end else begin
            r.res = {s, 5'h00, mm[9:0]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare process: every cycle outside reset, outputs must agree with the
    // pending expectation (or with the idle state when nothing is pending).
    always @(negedge clk) begin
        if (!rst) begin
            if (o_out_valid) begin
                if (!pend) begin
                    chk("spurious_valid", 32'(o_out_valid), 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 32'(cyc - acc_cyc - 1), 32'(exp_cur.lat));
                    end
                    chk("result", 32'(o_result), 32'(exp_cur.res));
                    chk("ovf", 32'(o_out_ovf), 32'(exp_cur.ovf));
                    chk("zero", 32'(o_out_zero), 32'(exp_cur.zero));
                    chk("busy_in_ready", 32'(o_in_ready), 32'd0);
                end
            end else if (pend && seen) begin
                chk("valid_dropped", 32'(o_out_valid), 32'd1);
            end else if (!pend) begin
                chk("idle_in_ready", 32'(o_in_ready), 32'd1);
                chk("idle_result", 32'(o_result), 32'(last_result));
                chk("idle_flags", 32'({o_out_ovf, o_out_zero}), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        pend = 1'b0; seen = 1'b0; last_result = '0;
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic start_txn(input logic s, input logic [11:0] m, input logic [4:0] ex);
        @(posedge clk); #1;
        i_in_valid = 1'b1; i_res_sign = s; i_m_sum = m; i_exp_in = ex;
        exp_cur = model(s, m, ex);
        acc_cyc = cyc;
        pend = 1'b1; seen = 1'b0;
        @(posedge clk); #1;
        // Busy: keep offering garbage, which must be ignored.
        i_in_valid = 1'b1;
        i_res_sign = 1'($urandom); i_m_sum = 12'($urandom); i_exp_in = 5'($urandom);
    endtask

    task automatic run_txn(input logic s, input logic [11:0] m, input logic [4:0] ex, input int hold);
        int t;
        start_txn(s, m, ex);
        t = 0;
        while (!o_out_valid && t < 20) begin @(posedge clk); #1; t++; end
        if (!o_out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: out_valid not seen within 20 cycles, m=0x%0h e=%0d", m, ex);
            do_reset();
            return;
        end
        repeat (hold) begin @(posedge clk); #1; end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0; i_in_valid = 1'b0;
        last_result = exp_cur.res;
        pend = 1'b0; seen = 1'b0;
    endtask

    initial begin
        exp_t        pm;
        logic [11:0] rm;
        logic [4:0]  rex;

        // Pin the model against hand-computed values.
        pm = model(1'b0, 12'h400, 5'd15); chk("model_norm", {pm.res, 16'(pm.lat)}, {16'h3C00, 16'd1});
        pm = model(1'b0, 12'h800, 5'd15); chk("model_carry", {pm.res, 16'(pm.lat)}, {16'h4000, 16'd2});
        pm = model(1'b0, 12'h001, 5'd15); chk("model_lshift", {pm.res, 16'(pm.lat)}, {16'h1400, 16'd11});
        pm = model(1'b0, 12'h010, 5'd3);  chk("model_subn", {pm.res, 16'(pm.lat)}, {16'h0040, 16'd3});
        pm = model(1'b1, 12'h800, 5'd30); chk("model_ovf", {pm.res, 15'd0, pm.ovf}, {16'hFC00, 16'd1});
        pm = model(1'b1, 12'h000, 5'd7);  chk("model_zero", {pm.res, 15'd0, pm.zero}, {16'h0000, 16'd1});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'({o_in_ready, o_out_valid, o_out_ovf, o_out_zero, o_result}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));

        run_txn(1'b0, 12'h400, 5'd15, 0);
        run_txn(1'b0, 12'h800, 5'd15, 1);
        run_txn(1'b0, 12'h001, 5'd15, 0);
        run_txn(1'b0, 12'h010, 5'd3, 2);
        run_txn(1'b1, 12'h800, 5'd30, 0);
        run_txn(1'b1, 12'h000, 5'd15, 5);
        run_txn(1'b0, 12'h400, 5'd0, 0);

        // Reset in the middle of a long left-shift run.
        start_txn(1'b0, 12'h001, 5'd15);
        repeat (3) begin @(posedge clk); #1; end
        do_reset();
        @(negedge clk);
        chk("rst_abort_in_ready", 32'(o_in_ready), 32'd1);
        repeat (15) @(posedge clk);
        #1;

        for (int n = 0; n < 250; n++) begin
            rm = 12'($urandom) >> $urandom_range(0, 11);
            if ($urandom_range(0, 9) == 0) rm = '0;
            rex = 5'($urandom_range(0, 30));
            if ($urandom_range(0, 7) == 0) rex = 5'($urandom_range(28, 30));
            run_txn(1'($urandom), rm, rex, $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
